// File: rtl/instr_fetch_sequencer_if.sv
// Memory-fetch and instruction-issue handshakes between the fetch sequencer,
// instruction memory and the control unit.
interface instr_fetch_sequencer_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [3:0]         opcode;
    logic [3:0]         rd;
    logic [3:0]         rs;
    logic [3:0]         rt;
    logic               issue_valid;
    logic               issue_ready;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;

    modport master (
        output imem_req, imem_addr, opcode, rd, rs, rt, issue_valid,
        input  imem_ack, imem_rdata, issue_ready, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, opcode, rd, rs, rt, issue_valid,
        output imem_ack, imem_rdata, issue_ready, branch_taken, branch_target
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetches instruction words over req/ack, holds them in IR and issues the
// decoded fields to the control unit over valid/ready; PC steps or branches.
module instr_fetch_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    instr_fetch_sequencer_if.master   bus,
    output logic [ADDR_W-1:0]         pc,
    output logic                      busy,
    output logic                      halted,
    output logic [15:0]               instr_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned FLD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, valid_q, busy_q, halted_q;

    // Next-state, PC, IR and counter update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.issue_ready) begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                    if (ir_q[INSTR_W-1 -: FLD_W] == HALT_OP) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = bus.branch_taken ? bus.branch_target : pc_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered status flags decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            req_q    <= (state_d == ST_FETCH);
            valid_q  <= (state_d == ST_ISSUE);
            busy_q   <= (state_d == ST_FETCH) || (state_d == ST_ISSUE);
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.issue_valid = valid_q;
    assign bus.opcode      = ir_q[INSTR_W-1 -: FLD_W];
    assign bus.rd          = ir_q[INSTR_W-5 -: FLD_W];
    assign bus.rs          = ir_q[INSTR_W-9 -: FLD_W];
    assign bus.rt          = ir_q[INSTR_W-13 -: FLD_W];
    assign pc              = pc_q;
    assign busy            = busy_q;
    assign halted          = halted_q;
    assign instr_count     = cnt_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Randomized bench for instr_fetch_sequencer: a memory/control-unit responder
// plus a program-flow reference model checked every cycle.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pc;
    logic        busy, halted;
    logic [15:0] instr_count;

    instr_fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

    instr_fetch_sequencer #(.ADDR_W(8), .INSTR_W(16), .HALT_OP(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .pc(pc), .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: phase 0 idle, 1 fetching, 2 issuing, 3 halted
    int          exp_phase = 0;
    logic [7:0]  exp_pc    = '0;
    logic [15:0] exp_cnt   = '0;
    logic [15:0] exp_ir    = '0;

    logic [15:0] mem    [256];
    bit          br_en  [256];
    logic [7:0]  br_tgt [256];
    logic [7:0]  fetch_log [$];
    int          issue_cyc [$];
    int          hold_len  [$];

    task automatic load_random_prog();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = {4'($urandom_range(0, 14)), 12'($urandom)};
            br_en[i] = 1'b0;
            br_tgt[i] = '0;
        end
        fetch_log.delete();
        issue_cyc.delete();
        hold_len.delete();
    endtask

    task automatic idle_inputs();
        start             = 1'b0;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        bus.issue_ready   = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
    endtask

    // Called at a negedge from IDLE or HALT; leaves the bench at the next negedge
    task automatic pulse_start();
        idle_inputs();
        start = 1'b1;
        @(posedge clk);
        cyc++;
        exp_phase = 1;
        exp_pc    = '0;
        exp_cnt   = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycle engine: checks DUT against the model, then drives memory/issue side.
    // ack_delay/ready_delay < 0 means random; stop_addr >= 0 returns while fetching it.
    task automatic run(input int ack_delay, input int ready_delay, input bit rand_br,
                       input bit start_noise, input int stop_addr, output bit reached);
        int req_run = 0;
        int vld_run = 0;
        int issued  = 0;
        bit ack, rdy, br;
        logic [7:0] tgt;
        logic [3:0] exp_flags;
        reached = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            exp_flags = {exp_phase == 1, exp_phase == 2,
                         exp_phase == 1 || exp_phase == 2, exp_phase == 3};
            n_tests++;
            if ({bus.imem_req, bus.issue_valid, busy, halted} !== exp_flags) begin
                n_fail++;
                $display("FAIL flags cyc=%0d req/valid/busy/halted got %b want %b",
                         cyc, {bus.imem_req, bus.issue_valid, busy, halted}, exp_flags);
            end
            n_tests++;
            if (pc !== exp_pc) begin
                n_fail++;
                $display("FAIL pc cyc=%0d got %h want %h", cyc, pc, exp_pc);
            end
            n_tests++;
            if (instr_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL instr_count cyc=%0d got %0d want %0d", cyc, instr_count, exp_cnt);
            end
            n_tests++;
            if ({bus.opcode, bus.rd, bus.rs, bus.rt} !== exp_ir) begin
                n_fail++;
                $display("FAIL fields cyc=%0d got %h want %h", cyc,
                         {bus.opcode, bus.rd, bus.rs, bus.rt}, exp_ir);
            end
            if (exp_phase == 1) begin
                n_tests++;
                if (bus.imem_addr !== exp_pc) begin
                    n_fail++;
                    $display("FAIL imem_addr cyc=%0d got %h want %h", cyc, bus.imem_addr, exp_pc);
                end
            end
            if (exp_phase == 3 || exp_phase == 0 ||
                (exp_phase == 1 && stop_addr >= 0 && int'(exp_pc) == stop_addr)) begin
                idle_inputs();
                reached = 1'b1;
                return;
            end

            ack = 1'b0;
            if (exp_phase == 1) begin
                req_run++;
                ack = (ack_delay < 0) ? ($urandom_range(0, 2) == 0) : (req_run > ack_delay);
            end else if (ack_delay < 0) begin
                ack = 1'($urandom_range(0, 1));
            end
            bus.imem_ack   = ack;
            bus.imem_rdata = (exp_phase == 1 && ack) ? mem[bus.imem_addr] : 16'($urandom);

            rdy = 1'b0;
            if (exp_phase == 2) begin
                vld_run++;
                rdy = (ready_delay < 0) ? 1'($urandom_range(0, 1)) : (vld_run > ready_delay);
            end else if (ready_delay < 0) begin
                rdy = 1'($urandom_range(0, 1));
            end
            br  = 1'($urandom_range(0, 1));
            tgt = 8'($urandom);
            if (exp_phase == 2 && rdy) begin
                if (br_en[exp_pc]) begin
                    br = 1'b1;
                    tgt = br_tgt[exp_pc];
                    br_en[exp_pc] = 1'b0;
                end else if (rand_br) begin
                    br = ($urandom_range(0, 3) == 0);
                    if (issued >= 30) begin
                        br = 1'b1;
                        tgt = 8'hF0;
                    end
                end else begin
                    br = 1'b0;
                end
            end
            bus.issue_ready   = rdy;
            bus.branch_taken  = br;
            bus.branch_target = tgt;
            start = (start_noise && (exp_phase == 1 || exp_phase == 2)) ? 1'($urandom_range(0, 1)) : 1'b0;

            if (exp_phase == 1 && ack) begin
                exp_ir = mem[exp_pc];
                fetch_log.push_back(exp_pc);
                hold_len.push_back(req_run);
                req_run = 0;
                exp_phase = 2;
            end else if (exp_phase == 2 && rdy) begin
                issue_cyc.push_back(cyc);
                issued++;
                vld_run = 0;
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                if (exp_ir[15:12] == 4'hF) begin
                    exp_phase = 3;
                end else begin
                    exp_pc = br ? tgt : exp_pc + 8'd1;
                    exp_phase = 1;
                end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL timeout cyc=%0d phase got %0d want halt", cyc, exp_phase);
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        exp_phase = 0; exp_pc = '0; exp_cnt = '0; exp_ir = '0;
        n_tests++;
        if ({bus.imem_req, bus.issue_valid, busy, halted, pc, instr_count, bus.opcode} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b vld=%b busy=%b halt=%b pc=%h cnt=%h op=%h want all 0",
                     bus.imem_req, bus.issue_valid, busy, halted, pc, instr_count, bus.opcode);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_straight_line();
        bit ok;
        load_random_prog();
        mem[0][15:12] = 4'h1; mem[1][15:12] = 4'h2; mem[2][15:12] = 4'h3;
        mem[3][15:12] = 4'h4; mem[4][15:12] = 4'hE; mem[5][15:12] = 4'hF;
        pulse_start();
        run(0, 0, 1'b0, 1'b0, -1, ok);
        n_tests++;
        if (issue_cyc.size() != 6) begin
            n_fail++;
            $display("FAIL straight_issues got %0d want 6", issue_cyc.size());
        end
        for (int i = 1; i < issue_cyc.size(); i++) begin
            n_tests++;
            if (issue_cyc[i] - issue_cyc[i-1] != 2) begin
                n_fail++;
                $display("FAIL straight_spacing idx=%0d got %0d want 2", i, issue_cyc[i] - issue_cyc[i-1]);
            end
        end
        n_tests++;
        if (halted !== 1'b1 || instr_count !== 16'd6 || pc !== 8'd5 || bus.opcode !== 4'hF) begin
            n_fail++;
            $display("FAIL straight_end got halt=%b cnt=%0d pc=%h op=%h want 1 6 05 f",
                     halted, instr_count, pc, bus.opcode);
        end
    endtask

    task automatic test_ack_delay();
        bit ok;
        load_random_prog();
        mem[3][15:12] = 4'hF;
        pulse_start();
        run(3, 0, 1'b0, 1'b0, -1, ok);
        foreach (hold_len[i]) begin
            n_tests++;
            if (hold_len[i] != 4) begin
                n_fail++;
                $display("FAIL ack_delay_hold idx=%0d got %0d want 4", i, hold_len[i]);
            end
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        load_random_prog();
        mem[0][15:12] = 4'h3; mem[1][15:12] = 4'h3; mem[2][15:12] = 4'hF;
        pulse_start();
        run(0, 5, 1'b0, 1'b0, -1, ok);
        n_tests++;
        if (instr_count !== 16'd3 || issue_cyc.size() != 3) begin
            n_fail++;
            $display("FAIL stall_count got %0d/%0d want 3", instr_count, issue_cyc.size());
        end
    endtask

    task automatic test_branch_wrap();
        bit ok;
        load_random_prog();
        br_en[8'h02] = 1'b1; br_tgt[8'h02] = 8'h40;
        br_en[8'h40] = 1'b1; br_tgt[8'h40] = 8'hFE;
        mem[3][15:12] = 4'hF;
        pulse_start();
        run(-1, -1, 1'b0, 1'b0, -1, ok);
        n_tests++;
        if (fetch_log.size() != 10 || fetch_log[3] !== 8'h40 || fetch_log[6] !== 8'h00) begin
            n_fail++;
            $display("FAIL branch_addrs got n=%0d [3]=%h [6]=%h want 10 40 00",
                     fetch_log.size(), fetch_log[3], fetch_log[6]);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        load_random_prog();
        mem[8][15:12] = 4'hF;
        pulse_start();
        run(1, 1, 1'b0, 1'b0, 7, ok);
        rst_n = 1'b0;
        #1;
        exp_phase = 0; exp_pc = '0; exp_cnt = '0; exp_ir = '0;
        n_tests++;
        if (bus.imem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h00) begin
            n_fail++;
            $display("FAIL midfetch_reset got req=%b busy=%b pc=%h want 0 0 00", bus.imem_req, busy, pc);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hF123;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.imem_req !== 1'b0 || busy !== 1'b0 || bus.opcode !== 4'h0) begin
            n_fail++;
            $display("FAIL late_ack got req=%b busy=%b op=%h want 0 0 0", bus.imem_req, busy, bus.opcode);
        end
        fetch_log.delete();
        pulse_start();
        run(-1, -1, 1'b0, 1'b0, -1, ok);
        n_tests++;
        if (fetch_log.size() == 0 || fetch_log[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL restart_addr got n=%0d want first fetch 00", fetch_log.size());
        end
    endtask

    task automatic test_start_ignored_restart();
        bit ok;
        load_random_prog();
        mem[4][15:12] = 4'hF;
        pulse_start();
        run(1, 2, 1'b0, 1'b1, -1, ok);
        n_tests++;
        if (halted !== 1'b1 || instr_count !== 16'd5 || pc !== 8'd4) begin
            n_fail++;
            $display("FAIL noisy_start got halt=%b cnt=%0d pc=%h want 1 5 04", halted, instr_count, pc);
        end
        pulse_start();
        n_tests++;
        if (pc !== 8'h00 || instr_count !== 16'd0 || bus.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_restart got pc=%h cnt=%0d req=%b want 00 0 1", pc, instr_count, bus.imem_req);
        end
        run(0, 0, 1'b0, 1'b0, -1, ok);
    endtask

    task automatic test_random();
        bit ok;
        for (int p = 0; p < 4; p++) begin
            load_random_prog();
            mem[8'hF0] = {4'hF, 12'($urandom)};
            pulse_start();
            run(-1, -1, 1'b1, 1'b1, -1, ok);
        end
    endtask

    initial begin
        idle_inputs();
        #3;
        test_reset();
        test_straight_line();
        test_ack_delay();
        test_ready_stall();
        test_branch_wrap();
        test_reset_mid_fetch();
        test_start_ignored_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
